i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: answers SLAVE_ADDR, hands received bytes to rx_data and sends tx_data on reads.
// The bus pins are oversampled on clk; sda is only ever pulled low (open drain).
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_load,
   output logic       rw,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_BYTE   = 3'd3,
      RX_ACK    = 3'd4,
      TX_BYTE   = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sclSync_q, sdaSync_q;
   logic       sclPrev_q, sdaPrev_q;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       drive_q, drive_d;
   logic       txFirst_q, txFirst_d;
   logic [7:0] rxData_q, rxData_d;
   logic       rxValid_q, rxValid_d;
   logic       txLoad_q, txLoad_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;

   logic       sclIn, sdaIn, sclRise, sclFall, startDet, stopDet;
   logic [7:0] shiftIn;

   assign sclIn    = sclSync_q[1];
   assign sdaIn    = sdaSync_q[1];
   assign sclRise  = sclIn & ~sclPrev_q;
   assign sclFall  = ~sclIn & sclPrev_q;
   assign startDet = sclIn & sclPrev_q & sdaPrev_q & ~sdaIn;
   assign stopDet  = sclIn & sclPrev_q & ~sdaPrev_q & sdaIn;
   assign shiftIn  = {shift_q[6:0], sdaIn};

   assign sda      = drive_q ? 1'b0 : 1'bz;
   assign rx_data  = rxData_q;
   assign rx_valid = rxValid_q;
   assign tx_load  = txLoad_q;
   assign rw       = rw_q;
   assign busy     = busy_q;

   // Synchronizers idle high so a quiet bus after reset shows no START/STOP
   always_ff @(posedge clk) begin
      if (rst) begin
         sclSync_q <= 2'b11;
         sdaSync_q <= 2'b11;
         sclPrev_q <= 1'b1;
         sdaPrev_q <= 1'b1;
      end else begin
         sclSync_q <= {sclSync_q[0], scl};
         sdaSync_q <= {sdaSync_q[0], sda};
         sclPrev_q <= sclIn;
         sdaPrev_q <= sdaIn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         shift_q   <= 8'h00;
         drive_q   <= 1'b0;
         txFirst_q <= 1'b0;
         rxData_q  <= 8'h00;
         rxValid_q <= 1'b0;
         txLoad_q  <= 1'b0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         drive_q   <= drive_d;
         txFirst_q <= txFirst_d;
         rxData_q  <= rxData_d;
         rxValid_q <= rxValid_d;
         txLoad_q  <= txLoad_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      drive_d   = drive_q;
      txFirst_d = txFirst_q;
      rxData_d  = rxData_q;
      rxValid_d = 1'b0;
      txLoad_d  = 1'b0;
      rw_d      = rw_q;
      busy_d    = busy_q;

      if (startDet) begin
         state_d = ADDR;
         cnt_d   = 3'd0;
         drive_d = 1'b0;
      end else if (stopDet) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         drive_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ADDR: if (sclRise) begin
               shift_d = shiftIn;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (shiftIn[7:1] == SLAVE_ADDR) begin
                     rw_d    = shiftIn[0];
                     busy_d  = 1'b1;
                     state_d = ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = WAIT_STOP;
                  end
               end
            end
            // First falling edge pulls the ACK low, the second ends the ACK slot
            ADDR_ACK, RX_ACK: if (sclFall) begin
               if (!drive_q) begin
                  drive_d = 1'b1;
               end else if (state_q == RX_ACK || !rw_q) begin
                  drive_d = 1'b0;
                  state_d = RX_BYTE;
               end else begin
                  shift_d   = tx_data;
                  txLoad_d  = 1'b1;
                  drive_d   = ~tx_data[7];
                  txFirst_d = 1'b0;
                  state_d   = TX_BYTE;
               end
            end
            RX_BYTE: if (sclRise) begin
               shift_d = shiftIn;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rxData_d  = shiftIn;
                  rxValid_d = 1'b1;
                  state_d   = RX_ACK;
               end
            end
            // A byte captured at the ACK rising edge puts its MSB out on the next fall
            TX_BYTE: if (sclFall) begin
               if (txFirst_q) begin
                  drive_d   = ~shift_q[7];
                  txFirst_d = 1'b0;
               end else if (cnt_q == 3'd7) begin
                  drive_d = 1'b0;
                  cnt_d   = 3'd0;
                  state_d = TX_ACK;
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
                  drive_d = ~shift_q[6];
               end
            end
            TX_ACK: if (sclRise) begin
               if (!sdaIn) begin
                  shift_d   = tx_data;
                  txLoad_d  = 1'b1;
                  txFirst_d = 1'b1;
                  cnt_d     = 3'd0;
                  state_d   = TX_BYTE;
               end else begin
                  state_d = WAIT_STOP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-bangs an I2C initiator on scl/sda and
// checks ACKs, received/transmitted bytes, pulses and state after each step.
module tb_i2c_slave;

   localparam int H = 128;
   localparam int Q = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       masterSda = 1'b1;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid, tx_load, rw, busy;

   int total = 0;
   int bad = 0;
   int rxValidCount = 0;
   int txLoadCount = 0;
   int slaveDrove = 0;
   int idleCount = 0;
   int txCount = 0;

   assign sda = masterSda ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl),
      .sda      (sda),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_load  (tx_load),
      .rw       (rw),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Event counters; checks compare deltas taken around each scenario
   always @(posedge clk) begin
      if (rx_valid) rxValidCount <= rxValidCount + 1;
      if (tx_load) txLoadCount <= txLoadCount + 1;
      if (masterSda && sda === 1'b0) slaveDrove <= slaveDrove + 1;
      if (dut.state_q == 3'd0) idleCount <= idleCount + 1;
      if (dut.state_q == 3'd5) txCount <= txCount + 1;
   end

   task automatic applyStimulus(input logic sclVal, input logic sdaVal, input int clocks);
      scl = sclVal;
      masterSda = sdaVal;
      repeat (clocks) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic startCond();
      applyStimulus(1'b0, masterSda, Q);
      applyStimulus(1'b0, 1'b1, H - Q);
      applyStimulus(1'b1, 1'b1, H);
      applyStimulus(1'b1, 1'b0, H);
   endtask

   task automatic stopCond();
      applyStimulus(1'b0, masterSda, Q);
      applyStimulus(1'b0, 1'b0, H - Q);
      applyStimulus(1'b1, 1'b0, H);
      applyStimulus(1'b1, 1'b1, H);
   endtask

   task automatic writeBit(input logic b);
      applyStimulus(1'b0, masterSda, Q);
      applyStimulus(1'b0, b, H - Q);
      applyStimulus(1'b1, b, H);
   endtask

   task automatic readBit(output logic b);
      applyStimulus(1'b0, masterSda, Q);
      applyStimulus(1'b0, 1'b1, H - Q);
      applyStimulus(1'b1, 1'b1, H / 2);
      b = sda;
      applyStimulus(1'b1, 1'b1, H / 2);
   endtask

   task automatic writeByte(input logic [7:0] data, output logic ack);
      for (int i = 7; i >= 0; i--) writeBit(data[i]);
      readBit(ack);
   endtask

   task automatic readByte(output logic [7:0] data);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         readBit(b);
         data[i] = b;
      end
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] rdByte;
      int         rxBase, txBase, droveBase, idleBase, txStateBase;

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("resetBusy", 32'(busy), 32'h0);
      checkOutput("resetRxData", 32'(rx_data), 32'h00);
      checkOutput("resetRxValid", 32'(rx_valid), 32'h0);
      checkOutput("resetTxLoad", 32'(tx_load), 32'h0);
      checkOutput("resetRw", 32'(rw), 32'h0);
      checkOutput("resetSda", 32'(sda), 32'h1);
      checkOutput("resetState", 32'(dut.state_q), 32'h0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 8);
      checkOutput("idleAfterReset", 32'(dut.state_q), 32'h0);

      $display("[TB] write A0 3C");
      rxBase = rxValidCount;
      startCond();
      writeByte(8'hA0, ack);
      checkOutput("wrAddrAck", 32'(ack), 32'h0);
      checkOutput("wrBusy", 32'(busy), 32'h1);
      checkOutput("wrRw", 32'(rw), 32'h0);
      writeByte(8'h3C, ack);
      checkOutput("wrDataAck", 32'(ack), 32'h0);
      checkOutput("wrRxData", 32'(rx_data), 32'h3C);
      checkOutput("wrRxValidCount", 32'(rxValidCount - rxBase), 32'h1);
      checkOutput("wrBusyBeforeStop", 32'(busy), 32'h1);
      stopCond();
      checkOutput("wrBusyAfterStop", 32'(busy), 32'h0);
      checkOutput("wrIdle", 32'(dut.state_q), 32'h0);

      $display("[TB] read A1 96 5A");
      tx_data = 8'h96;
      txBase = txLoadCount;
      startCond();
      writeByte(8'hA1, ack);
      checkOutput("rdAddrAck", 32'(ack), 32'h0);
      checkOutput("rdRw", 32'(rw), 32'h1);
      readByte(rdByte);
      checkOutput("rdByte1", 32'(rdByte), 32'h96);
      tx_data = 8'h5A;
      writeBit(1'b0);
      readByte(rdByte);
      checkOutput("rdByte2", 32'(rdByte), 32'h5A);
      writeBit(1'b1);
      applyStimulus(1'b0, 1'b1, Q);
      checkOutput("rdWaitStop", 32'(dut.state_q), 32'h7);
      checkOutput("rdTxLoadCount", 32'(txLoadCount - txBase), 32'h2);
      checkOutput("rdBusyInWait", 32'(busy), 32'h1);
      stopCond();
      checkOutput("rdIdle", 32'(dut.state_q), 32'h0);

      $display("[TB] address B0 not ours");
      rxBase = rxValidCount;
      droveBase = slaveDrove;
      startCond();
      writeByte(8'hB0, ack);
      checkOutput("nmAck", 32'(ack), 32'h1);
      checkOutput("nmBusy", 32'(busy), 32'h0);
      writeByte(8'h55, ack);
      checkOutput("nmDataAck", 32'(ack), 32'h1);
      checkOutput("nmWaitStop", 32'(dut.state_q), 32'h7);
      stopCond();
      checkOutput("nmIdle", 32'(dut.state_q), 32'h0);
      checkOutput("nmNeverDriven", 32'(slaveDrove - droveBase), 32'h0);
      checkOutput("nmNoRxValid", 32'(rxValidCount - rxBase), 32'h0);

      $display("[TB] repeated start");
      startCond();
      writeByte(8'hA0, ack);
      writeByte(8'h11, ack);
      checkOutput("rsRxData", 32'(rx_data), 32'h11);
      checkOutput("rsRwWrite", 32'(rw), 32'h0);
      idleBase = idleCount;
      txStateBase = txCount;
      startCond();
      writeByte(8'hA1, ack);
      checkOutput("rsAddrAck", 32'(ack), 32'h0);
      checkOutput("rsRwRead", 32'(rw), 32'h1);
      readByte(rdByte);
      writeBit(1'b1);
      checkOutput("rsTxEntered", 32'(txCount - txStateBase > 0), 32'h1);
      checkOutput("rsNoIdle", 32'(idleCount - idleBase), 32'h0);
      checkOutput("rsRxDataKept", 32'(rx_data), 32'h11);
      stopCond();

      $display("[TB] reset mid-transfer");
      tx_data = 8'h00;
      startCond();
      writeByte(8'hA1, ack);
      for (int i = 0; i < 3; i++) readBit(b);
      applyStimulus(1'b0, 1'b1, Q);
      checkOutput("mrSlaveDriving", 32'(sda), 32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1);
      rst = 1'b0;
      checkOutput("mrSdaReleased", 32'(sda), 32'h1);
      checkOutput("mrState", 32'(dut.state_q), 32'h0);
      checkOutput("mrBusy", 32'(busy), 32'h0);
      checkOutput("mrRw", 32'(rw), 32'h0);
      checkOutput("mrRxData", 32'(rx_data), 32'h00);
      checkOutput("mrTxLoad", 32'(tx_load), 32'h0);
      applyStimulus(1'b0, 1'b1, H);
      checkOutput("mrStillIdle", 32'(dut.state_q), 32'h0);
      startCond();
      writeByte(8'hA0, ack);
      checkOutput("mrReAck", 32'(ack), 32'h0);
      checkOutput("mrReBusy", 32'(busy), 32'h1);
      stopCond();

      $display("[TB] stop mid-byte");
      startCond();
      writeByte(8'hA0, ack);
      writeByte(8'h77, ack);
      checkOutput("smRxData77", 32'(rx_data), 32'h77);
      rxBase = rxValidCount;
      writeBit(1'b1);
      writeBit(1'b0);
      stopCond();
      checkOutput("smIdle", 32'(dut.state_q), 32'h0);
      checkOutput("smNoRxValid", 32'(rxValidCount - rxBase), 32'h0);
      checkOutput("smRxDataKept", 32'(rx_data), 32'h77);
      checkOutput("smBusy", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
